// File: rtl/button_conditioner.sv
// Pushbutton conditioner: per-button synchronizer and debounce FSM, then a
// fixed-priority winner (R > L > U > D) that drives one-cycle move strobes
// with an auto-repeat cadence while the winning button stays held.
module button_conditioner #(
    parameter int DB_COUNT      = 500000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnR,
    input  logic       btnL,
    input  logic       btnU,
    input  logic       btnD,
    output logic [3:0] db_level,
    output logic       right,
    output logic       left,
    output logic       up,
    output logic       down,
    output logic       any_held
);

    localparam int CW = 26;
    localparam logic [CW-1:0] DB_LAST     = CW'(DB_COUNT - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } state_t;

    typedef enum logic [2:0] {
        W_NONE,
        W_D,
        W_U,
        W_L,
        W_R
    } winner_t;

    // Channel index: 3=R, 2=L, 1=U, 0=D (matches db_level bit order).
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q;
    state_t        state_q [4];
    state_t        state_d [4];
    logic [CW-1:0] count_q [4];
    logic [CW-1:0] count_d [4];
    logic [3:0]    level_d;
    winner_t       winner_q, winner_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          first_q, first_d;
    logic [3:0]    strobe_d, strobe_q;
    logic [3:0]    db_level_q;
    logic          any_held_q;

    assign raw = {btnR, btnL, btnU, btnD};

    // Two-flop synchronizer on every raw button.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make each flop take its pre-edge input, so the two stages really delay by two edges.
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM state and stability counter per channel.
    always_ff @(posedge clk) begin
        // NOTE: these four-entry arrays are plain flops rather than a RAM, so they take the reset like any other register.
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_IDLE;
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Next debounce state: a level change needs DB_COUNT+1 agreeing samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            // NOTE: hold-current defaults on every path keep this block free of inferred latches.
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            unique case (state_q[i])
                S_IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_PRESS_WAIT;
                        count_d[i] = '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_IDLE;
                        count_d[i] = '0;
                    end else if (count_q[i] == DB_LAST) begin
                        state_d[i] = S_HELD;
                        count_d[i] = '0;
                    end else begin
                        count_d[i] = count_q[i] + CW'(1);
                    end
                end
                S_HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_RELEASE_WAIT;
                        count_d[i] = '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_HELD;
                        count_d[i] = '0;
                    end else if (count_q[i] == DB_LAST) begin
                        state_d[i] = S_IDLE;
                        count_d[i] = '0;
                    end else begin
                        count_d[i] = count_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    count_d[i] = '0;
                end
            endcase
        end
    end

    // Debounced level each channel will show after this edge.
    always_comb begin
        level_d = '0;
        for (int i = 0; i < 4; i++) begin
            level_d[i] = (state_d[i] == S_HELD) || (state_d[i] == S_RELEASE_WAIT);
        end
    end

    // Highest-priority held channel after this edge.
    always_comb begin
        winner_d = W_NONE;
        if (level_d[3])      winner_d = W_R;
        else if (level_d[2]) winner_d = W_L;
        else if (level_d[1]) winner_d = W_U;
        else if (level_d[0]) winner_d = W_D;
    end

    // Strobe and repeat timer: immediate strobe on a new winner, then DELAY, then PERIOD.
    always_comb begin
        timer_d  = timer_q;
        first_d  = first_q;
        strobe_d = '0;
        if (winner_d == W_NONE) begin
            timer_d = '0;
            first_d = 1'b1;
        end else if (winner_d != winner_q) begin
            timer_d = '0;
            first_d = 1'b1;
            strobe_d[winner_d - W_D] = 1'b1;
        end else if (timer_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
            timer_d = '0;
            first_d = 1'b0;
            strobe_d[winner_d - W_D] = 1'b1;
        end else begin
            timer_d = timer_q + CW'(1);
        end
    end

    // Output registers plus winner and repeat-timer state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_level_q <= '0;
            strobe_q   <= '0;
            any_held_q <= 1'b0;
            winner_q   <= W_NONE;
            timer_q    <= '0;
            first_q    <= 1'b1;
        end else begin
            db_level_q <= level_d;
            strobe_q   <= strobe_d;
            any_held_q <= |level_d;
            winner_q   <= winner_d;
            timer_q    <= timer_d;
            first_q    <= first_d;
        end
    end

    assign db_level                = db_level_q;
    assign {right, left, up, down} = strobe_q;
    assign any_held                = any_held_q;

endmodule
